// File: rtl/mydff_pkg.sv
// mydff_pkg
// Shared operation codes for the mydff universal register.
// Used by the register, its per-bit cell and the bench so the MODE
// encoding lives in exactly one place.
package mydff_pkg;

   localparam logic [2:0] MODE_HOLD  = 3'b000;
   localparam logic [2:0] MODE_LOAD  = 3'b001;
   localparam logic [2:0] MODE_SHL   = 3'b010;
   localparam logic [2:0] MODE_SHR   = 3'b011;
   localparam logic [2:0] MODE_ROL   = 3'b100;
   localparam logic [2:0] MODE_ROR   = 3'b101;
   localparam logic [2:0] MODE_CNTUP = 3'b110;
   localparam logic [2:0] MODE_CNTDN = 3'b111;

endpackage

// File: rtl/mydff_univ_cell.sv
// mydff_univ_cell
// One bit of the universal register: next-state mux plus flop.
// Ports:
//   Ck       clock, rising edge
//   CLR      synchronous clear, highest priority
//   PSET     synchronous preset, loads pset_bit
//   pset_bit this bit of the preset value
//   EN       enable for MODE operations
//   MODE     operation select (mydff_pkg codes)
//   d        parallel load bit
//   lo_bit   bit shifted in from below (SHL / ROL source)
//   hi_bit   bit shifted in from above (SHR / ROR source)
//   cnt_bit  this bit of the counter next value (up or down)
//   q        stored bit
module mydff_univ_cell
   import mydff_pkg::*;
(
   input  logic       Ck,
   input  logic       CLR,
   input  logic       PSET,
   input  logic       pset_bit,
   input  logic       EN,
   input  logic [2:0] MODE,
   input  logic       d,
   input  logic       lo_bit,
   input  logic       hi_bit,
   input  logic       cnt_bit,
   output logic       q
);

   logic r_q;

   always_ff @(posedge Ck) begin
      if (CLR)
         r_q <= 1'b0;
      else if (PSET)
         r_q <= pset_bit;
      else if (EN) begin
         case (MODE)
            MODE_LOAD:               r_q <= d;
            MODE_SHL, MODE_ROL:      r_q <= lo_bit;
            MODE_SHR, MODE_ROR:      r_q <= hi_bit;
            MODE_CNTUP, MODE_CNTDN:  r_q <= cnt_bit;
            default:                 r_q <= r_q;
         endcase
      end
   end

   assign q = r_q;

endmodule

// File: rtl/mydff_univ_reg.sv
// mydff_univ_reg
// WIDTH-bit universal register: clear, preset, enable, load, hold,
// shift/rotate left/right, count up/down.
// Ports:
//   Ck    clock, all state changes on the rising edge
//   CLR   synchronous clear (active-high), highest priority
//   PSET  synchronous preset (active-high), loads PSET_VAL
//   EN    enable for MODE operations
//   MODE  operation select (mydff_pkg codes)
//   D     parallel load data
//   SI    serial input for SHL/SHR
//   Q     register contents
//   SO    registered serial-out / carry-borrow pulse
//   ZERO  combinational, high when Q == 0
module mydff_univ_reg
   import mydff_pkg::*;
#(
   parameter int               WIDTH    = 8,
   parameter logic [WIDTH-1:0] PSET_VAL = {WIDTH{1'b1}}
) (
   input  logic             Ck,
   input  logic             CLR,
   input  logic             PSET,
   input  logic             EN,
   input  logic [2:0]       MODE,
   input  logic [WIDTH-1:0] D,
   input  logic             SI,
   output logic [WIDTH-1:0] Q,
   output logic             SO,
   output logic             ZERO
);

   logic [WIDTH-1:0] w_lo;
   logic [WIDTH-1:0] w_hi;
   logic [WIDTH-1:0] w_cnt;
   logic             w_lo_end;
   logic             w_hi_end;
   logic             r_so;

   // End bits differ between shift (take SI) and rotate (wrap around).
   // With WIDTH=1 this makes ROL/ROR hold and SHL/SHR load SI.
   assign w_lo_end = (MODE == MODE_ROL) ? Q[WIDTH-1] : SI;
   assign w_hi_end = (MODE == MODE_ROR) ? Q[0]       : SI;

   assign w_cnt = (MODE == MODE_CNTUP) ? Q + WIDTH'(1) : Q - WIDTH'(1);

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      if (i == 0) begin : g_lo_end
         assign w_lo[i] = w_lo_end;
      end else begin : g_lo_mid
         assign w_lo[i] = Q[i-1];
      end
      if (i == WIDTH-1) begin : g_hi_end
         assign w_hi[i] = w_hi_end;
      end else begin : g_hi_mid
         assign w_hi[i] = Q[i+1];
      end

      mydff_univ_cell u_cell (
         .Ck       (Ck),
         .CLR      (CLR),
         .PSET     (PSET),
         .pset_bit (PSET_VAL[i]),
         .EN       (EN),
         .MODE     (MODE),
         .d        (D[i]),
         .lo_bit   (w_lo[i]),
         .hi_bit   (w_hi[i]),
         .cnt_bit  (w_cnt[i]),
         .q        (Q[i])
      );
   end

   // SO is a one-edge pulse: the bit shifted/rotated out, or the wrap
   // indication of a count. Every other path drives it low.
   always_ff @(posedge Ck) begin
      if (CLR || PSET || !EN)
         r_so <= 1'b0;
      else begin
         case (MODE)
            MODE_SHL, MODE_ROL: r_so <= Q[WIDTH-1];
            MODE_SHR, MODE_ROR: r_so <= Q[0];
            MODE_CNTUP:         r_so <= &Q;
            MODE_CNTDN:         r_so <= ~|Q;
            default:            r_so <= 1'b0;
         endcase
      end
   end

   assign SO   = r_so;
   assign ZERO = ~|Q;

endmodule

// File: tb/tb_mydff_univ_reg.sv
// tb_mydff_univ_reg
// Directed table-driven bench for mydff_univ_reg (WIDTH=8, PSET_VAL=FF).
// Inputs change on the falling edge; outputs are checked 1 ns after the
// following rising edge against hand-computed values.
module tb_mydff_univ_reg;
   import mydff_pkg::*;

   localparam int W = 8;

   logic         Ck = 1'b0;
   logic         CLR, PSET, EN, SI;
   logic [2:0]   MODE;
   logic [W-1:0] D;
   logic [W-1:0] Q;
   logic         SO, ZERO;

   int n_checks = 0;
   int n_fail   = 0;

   always #10 Ck = ~Ck;

   mydff_univ_reg #(.WIDTH(W), .PSET_VAL(8'hFF)) dut (
      .Ck   (Ck),
      .CLR  (CLR),
      .PSET (PSET),
      .EN   (EN),
      .MODE (MODE),
      .D    (D),
      .SI   (SI),
      .Q    (Q),
      .SO   (SO),
      .ZERO (ZERO)
   );

   typedef struct {
      logic         clr;
      logic         pset;
      logic         en;
      logic [2:0]   mode;
      logic [W-1:0] d;
      logic         si;
      logic [W-1:0] exp_q;
      logic         exp_so;
      logic         exp_zero;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input logic clr, input logic pset,
                               input logic en, input logic [2:0] mode,
                               input logic [W-1:0] d, input logic si,
                               input logic [W-1:0] q, input logic so);
      vec_t v;
      v.clr = clr; v.pset = pset; v.en = en; v.mode = mode;
      v.d = d; v.si = si; v.exp_q = q; v.exp_so = so;
      v.exp_zero = (q == '0);
      vecs.push_back(v);
   endfunction

   task automatic check(input string name, input logic [W-1:0] act,
                        input logic [W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Drive one set of inputs, clock once, check Q/SO/ZERO.
   task automatic step(input string tag, input vec_t v);
      @(negedge Ck);
      CLR = v.clr; PSET = v.pset; EN = v.en; MODE = v.mode; D = v.d; SI = v.si;
      @(posedge Ck);
      #1;
      check({tag, " Q"},    Q,            v.exp_q);
      check({tag, " SO"},   W'(SO),       W'(v.exp_so));
      check({tag, " ZERO"}, W'(ZERO),     W'(v.exp_zero));
   endtask

   initial begin
      CLR = 1'b1; PSET = 1'b1; EN = 1'b1; MODE = MODE_LOAD; D = 8'hA5; SI = 1'b0;

      // clr pset en mode        d      si  Q      SO
      for (int i = 0; i < 5; i++)
         add(1, 1, 1, MODE_LOAD,  8'hA5, 0, 8'h00, 0);   // CLR beats PSET/LOAD
      add(0, 1, 1, MODE_LOAD,  8'hA5, 0, 8'hFF, 0);      // PSET beats LOAD
      add(0, 0, 1, MODE_LOAD,  8'hA5, 0, 8'hA5, 0);
      add(0, 0, 1, MODE_SHL,   8'h00, 1, 8'h4B, 1);
      add(0, 0, 1, MODE_SHL,   8'h00, 1, 8'h97, 0);
      add(0, 0, 1, MODE_SHR,   8'h00, 0, 8'h4B, 1);
      add(0, 0, 1, MODE_SHR,   8'h00, 1, 8'hA5, 1);      // SI enters at MSB
      add(0, 0, 1, MODE_LOAD,  8'h81, 0, 8'h81, 0);
      add(0, 0, 1, MODE_ROL,   8'h00, 0, 8'h03, 1);
      add(0, 0, 1, MODE_ROR,   8'h00, 0, 8'h81, 1);
      add(0, 0, 1, MODE_ROR,   8'h00, 0, 8'hC0, 1);
      add(0, 0, 1, MODE_ROL,   8'h00, 1, 8'h81, 1);      // SI ignored on rotate
      add(0, 0, 1, MODE_HOLD,  8'h55, 1, 8'h81, 0);      // SO pulse drops
      add(0, 0, 1, MODE_LOAD,  8'hFE, 0, 8'hFE, 0);
      add(0, 0, 1, MODE_CNTUP, 8'h00, 0, 8'hFF, 0);
      add(0, 0, 1, MODE_CNTUP, 8'h00, 0, 8'h00, 1);
      add(0, 0, 1, MODE_CNTUP, 8'h00, 0, 8'h01, 0);
      add(0, 0, 1, MODE_CNTDN, 8'h00, 0, 8'h00, 0);
      add(0, 0, 1, MODE_CNTDN, 8'h00, 0, 8'hFF, 1);
      add(0, 0, 1, MODE_LOAD,  8'h3C, 0, 8'h3C, 0);
      for (int i = 0; i < 4; i++)
         add(0, 0, 0, MODE_CNTUP, 8'hAA, 1, 8'h3C, 0);  // EN=0 holds
      add(0, 0, 1, MODE_ROL,   8'h00, 0, 8'h78, 0);
      add(1, 1, 1, MODE_CNTUP, 8'h00, 0, 8'h00, 0);
      add(0, 1, 1, MODE_CNTUP, 8'h00, 0, 8'hFF, 0);
      add(0, 1, 0, MODE_HOLD,  8'h00, 0, 8'hFF, 0);      // PSET ignores EN

      foreach (vecs[i])
         step($sformatf("vec%0d", i), vecs[i]);

      // CLR mid-count aborts the sequence; counting resumes from zero.
      begin
         vec_t v;
         v = '{clr:0, pset:0, en:1, mode:MODE_LOAD,  d:8'h10, si:0,
               exp_q:8'h10, exp_so:0, exp_zero:0};
         step("cnt load", v);
         v.mode = MODE_CNTUP; v.exp_q = 8'h11;
         step("cnt up1", v);
         v.exp_q = 8'h12;
         step("cnt up2", v);
         v.clr = 1; v.exp_q = 8'h00; v.exp_zero = 1;
         step("cnt clr", v);
         v.clr = 0; v.mode = MODE_CNTDN; v.exp_q = 8'hFF; v.exp_so = 1; v.exp_zero = 0;
         step("cnt dn wrap", v);
         v.en = 0; v.exp_so = 0;
         step("cnt dis", v);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
